// File: rtl/ctrl_sequencer.sv
// Decode-stage control unit that expands CALL/RET/RTI/interrupt entry into per-beat stack micro-ops.
// Optional stall-cycle counter output enabled by defining CTRL_STALL_CNT_EN.
module ctrl_sequencer #(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ALU_W    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [OPCODE_W-1:0]               opcode,
    input  logic                              instr_valid,
    input  logic                              stall_in,
    input  logic                              intr_req,
    output logic                              reg_write,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic                              mem_or_reg,
    output logic                              update_status,
    output logic                              imm_or_reg,
    output logic [ALU_W-1:0]                  alu_control,
    output logic [1:0]                        sp_op,
    output logic [1:0]                        carry_flag,
    output logic                              branch_flag,
    output logic                              pc_control,
    output logic                              private_reg_write,
    output logic [$clog2(PC_W/DATA_W+1)-1:0]  beat_idx,
    output logic                              fetch_stall,
    output logic                              busy,
`ifdef CTRL_STALL_CNT_EN
    output logic [15:0]                       stall_cycles,
`endif
    output logic                              intr_ack
);

    localparam int unsigned BEATS  = PC_W / DATA_W;
    localparam int unsigned BEAT_W = $clog2(BEATS + 1);

    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;

    localparam logic [OPCODE_W-1:0] OP_SETC = OPCODE_W'(5'b00001);
    localparam logic [OPCODE_W-1:0] OP_CLRC = OPCODE_W'(5'b00010);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(5'b01000);
    localparam logic [OPCODE_W-1:0] OP_LDD  = OPCODE_W'(5'b10000);
    localparam logic [OPCODE_W-1:0] OP_STD  = OPCODE_W'(5'b10001);
    localparam logic [OPCODE_W-1:0] OP_PUSH = OPCODE_W'(5'b10010);
    localparam logic [OPCODE_W-1:0] OP_POP  = OPCODE_W'(5'b10011);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(5'b10100);
    localparam logic [OPCODE_W-1:0] OP_CALL = OPCODE_W'(5'b11000);
    localparam logic [OPCODE_W-1:0] OP_RET  = OPCODE_W'(5'b11001);
    localparam logic [OPCODE_W-1:0] OP_RTI  = OPCODE_W'(5'b11010);

    typedef enum logic [2:0] {IDLE, PUSH_PC, POP_PC, PUSH_FLG, POP_FLG, JUMP} state_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_or_reg;
        logic             update_status;
        logic             imm_or_reg;
        logic [ALU_W-1:0] alu_control;
        logic [1:0]       sp_op;
        logic [1:0]       carry_flag;
        logic             branch_flag;
        logic             pc_control;
        logic             private_reg_write;
        logic             fetch_stall;
        logic             busy;
        logic             intr_ack;
    } ctrl_t;

    state_t            state, state_n;
    logic [BEAT_W-1:0] beat, beat_n;
    logic              is_rti, is_rti_n;
    ctrl_t             ctrl, ctrl_n;
    logic              last_beat;

    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    // Next state and the control word that describes it; a stall freezes everything.
    always_comb begin
        state_n  = state;
        beat_n   = beat;
        is_rti_n = is_rti;
        ctrl_n   = ctrl;
        if (!stall_in) begin
            beat_n = '0;
            ctrl_n = '0;
            case (state)
                IDLE: begin
                    if (intr_req) begin
                        state_n = PUSH_FLG;
                    end else if (instr_valid) begin
                        if (opcode == OP_CALL) begin
                            state_n  = PUSH_PC;
                        end else if (opcode == OP_RET || opcode == OP_RTI) begin
                            state_n  = POP_PC;
                            is_rti_n = (opcode == OP_RTI);
                        end
                    end
                end
                PUSH_FLG: state_n = PUSH_PC;
                PUSH_PC: begin
                    if (last_beat) state_n = JUMP;
                    else           beat_n  = beat + BEAT_W'(1);
                end
                POP_PC: begin
                    if (!last_beat)  beat_n  = beat + BEAT_W'(1);
                    else if (is_rti) state_n = POP_FLG;
                    else             state_n = JUMP;
                end
                POP_FLG: state_n = JUMP;
                default: state_n = IDLE;
            endcase

            case (state_n)
                PUSH_FLG: begin
                    ctrl_n.mem_write = 1'b1;
                    ctrl_n.sp_op     = SP_PUSH;
                    ctrl_n.intr_ack  = 1'b1;
                end
                PUSH_PC: begin
                    ctrl_n.mem_write = 1'b1;
                    ctrl_n.sp_op     = SP_PUSH;
                end
                POP_PC: begin
                    ctrl_n.mem_read = 1'b1;
                    ctrl_n.sp_op    = SP_POP;
                end
                POP_FLG: begin
                    ctrl_n.mem_read          = 1'b1;
                    ctrl_n.sp_op             = SP_POP;
                    ctrl_n.update_status     = 1'b1;
                    ctrl_n.private_reg_write = 1'b1;
                end
                JUMP: ctrl_n.pc_control = 1'b1;
                default: begin
                    // Single-cycle decode only for an instruction actually accepted from IDLE.
                    if (state == IDLE && !intr_req && instr_valid) begin
                        case (opcode)
                            OP_SETC: begin
                                ctrl_n.update_status = 1'b1;
                                ctrl_n.carry_flag    = 2'b11;
                            end
                            OP_CLRC: begin
                                ctrl_n.update_status = 1'b1;
                                ctrl_n.carry_flag    = 2'b10;
                            end
                            OP_ADD: begin
                                ctrl_n.reg_write     = 1'b1;
                                ctrl_n.alu_control   = ALU_W'(1);
                                ctrl_n.update_status = 1'b1;
                            end
                            OP_LDD: begin
                                ctrl_n.mem_read   = 1'b1;
                                ctrl_n.mem_or_reg = 1'b1;
                                ctrl_n.reg_write  = 1'b1;
                                ctrl_n.imm_or_reg = 1'b1;
                            end
                            OP_STD: begin
                                ctrl_n.mem_write  = 1'b1;
                                ctrl_n.imm_or_reg = 1'b1;
                            end
                            OP_PUSH: begin
                                ctrl_n.mem_write = 1'b1;
                                ctrl_n.sp_op     = SP_PUSH;
                            end
                            OP_POP: begin
                                ctrl_n.mem_read   = 1'b1;
                                ctrl_n.sp_op      = SP_POP;
                                ctrl_n.reg_write  = 1'b1;
                                ctrl_n.mem_or_reg = 1'b1;
                            end
                            OP_JMP:  ctrl_n.branch_flag = 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
            ctrl_n.fetch_stall = (state_n != IDLE);
            ctrl_n.busy        = (state_n != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            beat   <= '0;
            is_rti <= 1'b0;
            ctrl   <= '0;
        end else begin
            state  <= state_n;
            beat   <= beat_n;
            is_rti <= is_rti_n;
            ctrl   <= ctrl_n;
        end
    end

`ifdef CTRL_STALL_CNT_EN
    // Saturating count of cycles in which fetch is held or downstream is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                stall_cycles <= '0;
        else if ((ctrl.fetch_stall || stall_in) && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
`endif

    assign reg_write         = ctrl.reg_write;
    assign mem_read          = ctrl.mem_read;
    assign mem_write         = ctrl.mem_write;
    assign mem_or_reg        = ctrl.mem_or_reg;
    assign update_status     = ctrl.update_status;
    assign imm_or_reg        = ctrl.imm_or_reg;
    assign alu_control       = ctrl.alu_control;
    assign sp_op             = ctrl.sp_op;
    assign carry_flag        = ctrl.carry_flag;
    assign branch_flag       = ctrl.branch_flag;
    assign pc_control        = ctrl.pc_control;
    assign private_reg_write = ctrl.private_reg_write;
    assign beat_idx          = beat;
    assign fetch_stall       = ctrl.fetch_stall;
    assign busy              = ctrl.busy;
    assign intr_ack          = ctrl.intr_ack;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with default parameters (BEATS = 2).
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] opcode;
    logic       instr_valid, stall_in, intr_req;
    logic       reg_write, mem_read, mem_write, mem_or_reg, update_status, imm_or_reg;
    logic [3:0] alu_control;
    logic [1:0] sp_op, carry_flag;
    logic       branch_flag, pc_control, private_reg_write;
    logic [1:0] beat_idx;
    logic       fetch_stall, busy, intr_ack;
`ifdef CTRL_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
        .stall_in(stall_in), .intr_req(intr_req),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_or_reg(mem_or_reg), .update_status(update_status), .imm_or_reg(imm_or_reg),
        .alu_control(alu_control), .sp_op(sp_op), .carry_flag(carry_flag),
        .branch_flag(branch_flag), .pc_control(pc_control),
        .private_reg_write(private_reg_write), .beat_idx(beat_idx),
        .fetch_stall(fetch_stall), .busy(busy),
`ifdef CTRL_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .intr_ack(intr_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {rw, mr, mw, mor, us, ior, alu[3:0], sp[1:0], cf[1:0], bf, pc, prw}
    function automatic logic [16:0] cw(int rw, int mr, int mw, int mor, int us, int ior,
                                       int alu, int sp, int cf, int bf, int pc, int prw);
        return {rw[0], mr[0], mw[0], mor[0], us[0], ior[0], alu[3:0], sp[1:0], cf[1:0],
                bf[0], pc[0], prw[0]};
    endfunction

    function automatic logic [16:0] dut_word();
        return {reg_write, mem_read, mem_write, mem_or_reg, update_status, imm_or_reg,
                alu_control, sp_op, carry_flag, branch_flag, pc_control, private_reg_write};
    endfunction

    task automatic expect_out(input string tag, input logic [16:0] w, input int beat,
                              input logic stl, input logic ack);
        check({tag, "/word"}, 32'(dut_word()), 32'(w));
        check({tag, "/beat"}, 32'(beat_idx), 32'(beat));
        check({tag, "/stall"}, 32'({fetch_stall, busy}), 32'({stl, stl}));
        check({tag, "/ack"}, 32'(intr_ack), 32'(ack));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [16:0] w_zero, w_push, w_pop, w_jump, w_popflg, w_add;
    logic [4:0]  dec_op [9];
    logic [16:0] dec_w  [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        w_zero   = cw(0,0,0,0,0,0, 0,0,0, 0,0,0);
        w_push   = cw(0,0,1,0,0,0, 0,1,0, 0,0,0);
        w_pop    = cw(0,1,0,0,0,0, 0,2,0, 0,0,0);
        w_jump   = cw(0,0,0,0,0,0, 0,0,0, 0,1,0);
        w_popflg = cw(0,1,0,0,1,0, 0,2,0, 0,0,1);
        w_add    = cw(1,0,0,0,1,0, 1,0,0, 0,0,0);

        dec_op[0] = 5'b00001; dec_w[0] = cw(0,0,0,0,1,0, 0,0,3, 0,0,0);
        dec_op[1] = 5'b00010; dec_w[1] = cw(0,0,0,0,1,0, 0,0,2, 0,0,0);
        dec_op[2] = 5'b01000; dec_w[2] = w_add;
        dec_op[3] = 5'b10000; dec_w[3] = cw(1,1,0,1,0,1, 0,0,0, 0,0,0);
        dec_op[4] = 5'b10001; dec_w[4] = cw(0,0,1,0,0,1, 0,0,0, 0,0,0);
        dec_op[5] = 5'b10010; dec_w[5] = w_push;
        dec_op[6] = 5'b10011; dec_w[6] = cw(1,1,0,1,0,0, 0,2,0, 0,0,0);
        dec_op[7] = 5'b10100; dec_w[7] = cw(0,0,0,0,0,0, 0,0,0, 1,0,0);
        dec_op[8] = 5'b00111; dec_w[8] = w_zero;

        reset = 1'b1; opcode = '0; instr_valid = 1'b0; stall_in = 1'b0; intr_req = 1'b0;
        tick(); tick();
        expect_out("reset", w_zero, 0, 1'b0, 1'b0);
        reset = 1'b0;

        // Single-cycle decode table
        for (int i = 0; i < 9; i++) begin
            opcode = dec_op[i]; instr_valid = 1'b1;
            tick();
            expect_out($sformatf("dec_%05b", dec_op[i]), dec_w[i], 0, 1'b0, 1'b0);
        end
        instr_valid = 1'b0;
        tick();
        expect_out("no_valid", w_zero, 0, 1'b0, 1'b0);

        // CALL: two push beats, jump, back to idle
        opcode = 5'b11000; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        expect_out("call_b0", w_push, 0, 1'b1, 1'b0);
        tick(); expect_out("call_b1", w_push, 1, 1'b1, 1'b0);
        tick(); expect_out("call_jmp", w_jump, 0, 1'b1, 1'b0);
        tick(); expect_out("call_idle", w_zero, 0, 1'b0, 1'b0);

        // RTI with a 3-cycle stall on beat 1
        opcode = 5'b11010; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        expect_out("rti_b0", w_pop, 0, 1'b1, 1'b0);
        tick(); expect_out("rti_b1", w_pop, 1, 1'b1, 1'b0);
        stall_in = 1'b1; intr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out($sformatf("rti_frz%0d", i), w_pop, 1, 1'b1, 1'b0);
        end
        stall_in = 1'b0; intr_req = 1'b0;
        tick(); expect_out("rti_flg", w_popflg, 0, 1'b1, 1'b0);
        tick(); expect_out("rti_jmp", w_jump, 0, 1'b1, 1'b0);
        tick(); expect_out("rti_idle", w_zero, 0, 1'b0, 1'b0);

        // Stall in IDLE: ADD and interrupt both ignored, outputs hold
        opcode = 5'b01000; instr_valid = 1'b1; intr_req = 1'b1; stall_in = 1'b1;
        tick(); expect_out("idle_stall", w_zero, 0, 1'b0, 1'b0);

        // Interrupt wins over a valid ADD
        stall_in = 1'b0;
        tick(); intr_req = 1'b0; instr_valid = 1'b0;
        expect_out("int_flg", w_push, 0, 1'b1, 1'b1);
        tick(); expect_out("int_b0", w_push, 0, 1'b1, 1'b0);
        tick(); expect_out("int_b1", w_push, 1, 1'b1, 1'b0);
        tick(); expect_out("int_jmp", w_jump, 0, 1'b1, 1'b0);
        tick(); expect_out("int_idle", w_zero, 0, 1'b0, 1'b0);

        // Reset mid-RET, then normal decode
        opcode = 5'b11001; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        expect_out("ret_b0", w_pop, 0, 1'b1, 1'b0);
        tick(); expect_out("ret_b1", w_pop, 1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 expect_out("ret_rst", w_zero, 0, 1'b0, 1'b0);
        tick(); reset = 1'b0;
        opcode = 5'b01000; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        expect_out("post_rst_add", w_add, 0, 1'b0, 1'b0);

`ifdef CTRL_STALL_CNT_EN
        opcode = 5'b11000; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick(); tick(); tick();
        check("stall_cnt_call", 32'(stall_cycles), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
